hazard_ctrl_mc: RTL and testbench

- Parametrised front-end/issue hazard controller; successor to the single-branch, two-RS hazard unit.
- Sits between IF/IS and the issue/execute stages. Generates fetch/issue enables, per-RS-class dispatch, ROB enable, and per-channel writeback enables/exec stalls.
- Tracks up to MAX_BR unresolved branches with a counter.
- Owns a multi-cycle flush FSM on misprediction.

---
 rtl/hazard_ctrl_mc.sv | 184 ++++++++++++++++++
 tb/tb_hazard_ctrl_mc.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc - front-end / issue hazard controller.
//
// Purpose:
//   Generates fetch and issue enables, a one-hot reservation-station dispatch
//   enable, ROB allocate, and per-channel writeback enables / exec stalls.
//   Tracks up to MAX_BR unresolved branches and runs a multi-cycle flush FSM
//   (RUN / FLUSH) after a misprediction.
//
// Optional feature macro: HAZARD_STATS_EN
//   Defined   : stall_cycles counts RUN cycles where a valid IS instruction
//               is stalled, saturating at all-ones, cleared only by reset.
//   Undefined : no counter flop, stall_cycles is tied to 0.
//
// Ports:
//   clock, reset_n              clock, asynchronous active-low reset
//   dec_valid/class/is_branch   IS-stage instruction description
//   rs_full, rob_full           back-pressure from RS classes and ROB
//   br_resolve, br_mispredict   branch resolution from exec
//   mem_wr_commit, mem_rd_req   memory port users (structural hazard)
//   wb_valid, wb_written        per-channel writeback state
//   if_enable, if_is_enable, if_is_flush   fetch / IF-IS register control
//   dispatch_en, rob_enable     issue side enables
//   wb_enable, exec_stall       per-channel writeback control
//   br_inflight                 unresolved branch count
//   flush_busy                  FSM is in FLUSH
//   stall_cycles                IS stall statistics (0 without the feature)

module hazard_ctrl_mc #(
    parameter int NUM_WB    = 3,
    parameter int NUM_RS    = 2,
    parameter int MAX_BR    = 4,
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 16,
    localparam int CW = (NUM_RS > 1) ? $clog2(NUM_RS) : 1,
    localparam int BW = $clog2(MAX_BR + 1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              dec_valid,
    input  logic [CW-1:0]     dec_class,
    input  logic              dec_is_branch,
    input  logic [NUM_RS-1:0] rs_full,
    input  logic              rob_full,
    input  logic              br_resolve,
    input  logic              br_mispredict,
    input  logic              mem_wr_commit,
    input  logic              mem_rd_req,
    input  logic [NUM_WB-1:0] wb_valid,
    input  logic [NUM_WB-1:0] wb_written,
    output logic              if_enable,
    output logic              if_is_enable,
    output logic              if_is_flush,
    output logic [NUM_RS-1:0] dispatch_en,
    output logic              rob_enable,
    output logic [NUM_WB-1:0] wb_enable,
    output logic [NUM_WB-1:0] exec_stall,
    output logic [BW-1:0]     br_inflight,
    output logic              flush_busy,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t         state_q;
    logic [FW-1:0]  flush_cnt_q;
    logic [BW-1:0]  br_cnt_q;
    logic [BW-1:0]  br_cnt_d;

    logic [NUM_RS-1:0] class_hit;
    logic [NUM_RS-1:0] rs_hit;
    logic              class_oob;
    logic              is_stall;
    logic              is_enable;
    logic              mem_hz;
    logic              run_normal;
    logic              br_inc;
    logic              br_dec;

    // Writeback channels: a channel may load when empty or being drained.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_WB; gi++) begin : g_wb
            assign wb_enable[gi]  = ~wb_valid[gi] | wb_written[gi];
            assign exec_stall[gi] = wb_valid[gi] & ~wb_written[gi];
        end
        // Class decode doubles as the rs_full selector, so an out-of-range
        // class never indexes past the rs_full vector.
        for (gi = 0; gi < NUM_RS; gi++) begin : g_rs
            assign class_hit[gi] = (dec_class == CW'(gi));
            assign rs_hit[gi]    = class_hit[gi] & rs_full[gi];
        end
    endgenerate

    assign class_oob = ({1'b0, dec_class} >= (CW + 1)'(NUM_RS));
    assign is_stall  = rob_full | (|rs_hit) | class_oob
                     | (dec_is_branch & (br_cnt_q == BW'(MAX_BR)));
    assign mem_hz    = mem_wr_commit | mem_rd_req;

    // Normal RUN behaviour; redirect and FLUSH cycles share one output set.
    assign run_normal = (state_q == RUN) & ~br_mispredict;
    assign is_enable  = run_normal & dec_valid & ~is_stall;

    assign dispatch_en  = is_enable ? class_hit : '0;
    assign rob_enable   = is_enable;
    assign if_enable    = run_normal ? ~(mem_hz | is_stall) : ~mem_hz;
    assign if_is_enable = run_normal ? ~is_stall : 1'b1;
    assign if_is_flush  = run_normal ? (mem_hz & ~is_stall) : 1'b1;

    // Branch counter: mispredict clears and overrides any increment;
    // simultaneous inc/dec cancel; decrement saturates at zero.
    assign br_inc = is_enable & dec_is_branch;
    assign br_dec = br_resolve & ~br_mispredict;

    always_comb begin
        br_cnt_d = br_cnt_q;
        if (br_mispredict) begin
            br_cnt_d = '0;
        end else if (br_inc & ~br_dec) begin
            br_cnt_d = br_cnt_q + 1'b1;
        end else if (~br_inc & br_dec & (br_cnt_q != '0)) begin
            br_cnt_d = br_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            br_cnt_q <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
        end
    end

    // Flush FSM: a mispredict in either state (re)loads the hold counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (br_mispredict) begin
                        state_q     <= FLUSH;
                        flush_cnt_q <= FW'(FLUSH_CYC - 1);
                    end
                end
                FLUSH: begin
                    if (br_mispredict) begin
                        flush_cnt_q <= FW'(FLUSH_CYC - 1);
                    end else if (flush_cnt_q == '0) begin
                        state_q <= RUN;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q     <= RUN;
                    flush_cnt_q <= '0;
                end
            endcase
        end
    end

    assign br_inflight = br_cnt_q;
    assign flush_busy  = (state_q == FLUSH);

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else if ((state_q == RUN) & dec_valid & is_stall & ~(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
module tb_hazard_ctrl_mc;

    localparam int CNT_W = 4;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       dec_valid;
    logic [0:0] dec_class;
    logic       dec_is_branch;
    logic [1:0] rs_full;
    logic       rob_full;
    logic       br_resolve;
    logic       br_mispredict;
    logic       mem_wr_commit;
    logic       mem_rd_req;
    logic [2:0] wb_valid;
    logic [2:0] wb_written;
    logic       if_enable;
    logic       if_is_enable;
    logic       if_is_flush;
    logic [1:0] dispatch_en;
    logic       rob_enable;
    logic [2:0] wb_enable;
    logic [2:0] exec_stall;
    logic [2:0] br_inflight;
    logic       flush_busy;
    logic [CNT_W-1:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    hazard_ctrl_mc #(
        .NUM_WB(3), .NUM_RS(2), .MAX_BR(4), .FLUSH_CYC(2), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .dec_valid(dec_valid), .dec_class(dec_class), .dec_is_branch(dec_is_branch),
        .rs_full(rs_full), .rob_full(rob_full),
        .br_resolve(br_resolve), .br_mispredict(br_mispredict),
        .mem_wr_commit(mem_wr_commit), .mem_rd_req(mem_rd_req),
        .wb_valid(wb_valid), .wb_written(wb_written),
        .if_enable(if_enable), .if_is_enable(if_is_enable), .if_is_flush(if_is_flush),
        .dispatch_en(dispatch_en), .rob_enable(rob_enable),
        .wb_enable(wb_enable), .exec_stall(exec_stall),
        .br_inflight(br_inflight), .flush_busy(flush_busy), .stall_cycles(stall_cycles)
    );

    typedef struct {
        string      name;
        logic       v;
        logic       cls;
        logic       br;
        logic [1:0] rsf;
        logic       robf;
        logic       mis;
        logic       mwr;
        logic       mrd;
        logic [2:0] wbv;
        logic [2:0] wbw;
        logic       e_if;
        logic       e_ifis;
        logic       e_flush;
        logic [1:0] e_disp;
        logic       e_rob;
        logic [2:0] e_wben;
        logic [2:0] e_xst;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    task automatic idle();
        dec_valid = 0; dec_class = 0; dec_is_branch = 0; rs_full = 0; rob_full = 0;
        br_resolve = 0; br_mispredict = 0; mem_wr_commit = 0; mem_rd_req = 0;
        wb_valid = 0; wb_written = 0;
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        //          name        v  c  br rsf    rob mis mwr mrd wbv     wbw     if ifis fl disp   rob wben    xst
        vecs[0]  = '{"disp_c1",  1, 1, 0, 2'b00, 0, 0, 0, 0, 3'b000, 3'b000, 1, 1, 0, 2'b10, 1, 3'b111, 3'b000};
        vecs[1]  = '{"disp_c0",  1, 0, 0, 2'b00, 0, 0, 0, 0, 3'b000, 3'b000, 1, 1, 0, 2'b01, 1, 3'b111, 3'b000};
        vecs[2]  = '{"rs1_full", 1, 1, 0, 2'b10, 0, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 2'b00, 0, 3'b111, 3'b000};
        vecs[3]  = '{"rs_other", 1, 0, 0, 2'b10, 0, 0, 0, 0, 3'b000, 3'b000, 1, 1, 0, 2'b01, 1, 3'b111, 3'b000};
        vecs[4]  = '{"rob_full", 1, 0, 0, 2'b00, 1, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 2'b00, 0, 3'b111, 3'b000};
        vecs[5]  = '{"mem_wr",   1, 0, 0, 2'b00, 0, 0, 1, 0, 3'b000, 3'b000, 0, 1, 1, 2'b01, 1, 3'b111, 3'b000};
        vecs[6]  = '{"mem_stall",1, 0, 0, 2'b00, 1, 0, 0, 1, 3'b000, 3'b000, 0, 0, 0, 2'b00, 0, 3'b111, 3'b000};
        vecs[7]  = '{"redirect", 1, 1, 0, 2'b00, 0, 1, 0, 0, 3'b000, 3'b000, 1, 1, 1, 2'b00, 0, 3'b111, 3'b000};
        vecs[8]  = '{"redir_mem",1, 0, 0, 2'b00, 1, 1, 0, 1, 3'b000, 3'b000, 0, 1, 1, 2'b00, 0, 3'b111, 3'b000};
        vecs[9]  = '{"wb_101",   0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b101, 3'b100, 1, 1, 0, 2'b00, 0, 3'b110, 3'b001};
        vecs[10] = '{"wb_full",  0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b111, 3'b000, 1, 1, 0, 2'b00, 0, 3'b000, 3'b111};
        vecs[11] = '{"idle_rob", 0, 0, 0, 2'b00, 1, 0, 0, 0, 3'b010, 3'b010, 0, 0, 0, 2'b00, 0, 3'b111, 3'b000};

        idle();
        reset_n = 0;
        #2;
        check("rst_inflight", 32'(br_inflight), 0);
        check("rst_busy", 32'(flush_busy), 0);
        check("rst_stats", 32'(stall_cycles), 0);
        @(negedge clock);
        reset_n = 1;
        @(negedge clock);

        // Combinational vectors, applied and withdrawn inside the low phase.
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            dec_valid = vecs[i].v; dec_class = vecs[i].cls; dec_is_branch = vecs[i].br;
            rs_full = vecs[i].rsf; rob_full = vecs[i].robf; br_mispredict = vecs[i].mis;
            br_resolve = vecs[i].mis; mem_wr_commit = vecs[i].mwr; mem_rd_req = vecs[i].mrd;
            wb_valid = vecs[i].wbv; wb_written = vecs[i].wbw;
            #1;
            check({vecs[i].name, ".if_en"},   32'(if_enable),    32'(vecs[i].e_if));
            check({vecs[i].name, ".ifis_en"}, 32'(if_is_enable), 32'(vecs[i].e_ifis));
            check({vecs[i].name, ".flush"},   32'(if_is_flush),  32'(vecs[i].e_flush));
            check({vecs[i].name, ".disp"},    32'(dispatch_en),  32'(vecs[i].e_disp));
            check({vecs[i].name, ".rob"},     32'(rob_enable),   32'(vecs[i].e_rob));
            check({vecs[i].name, ".wb_en"},   32'(wb_enable),    32'(vecs[i].e_wben));
            check({vecs[i].name, ".xstall"},  32'(exec_stall),   32'(vecs[i].e_xst));
            #1;
            idle();
        end
        check("vec_inflight", 32'(br_inflight), 0);
        check("vec_busy", 32'(flush_busy), 0);

        // Fill the branch tracker to MAX_BR, then a 5th branch stalls.
        @(negedge clock);
        dec_valid = 1; dec_class = 0; dec_is_branch = 1;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("br_fill%0d", k), 32'(br_inflight), k);
        end
        #1;
        check("br5_disp", 32'(dispatch_en), 0);
        check("br5_ifis", 32'(if_is_enable), 0);
        check("br5_ifen", 32'(if_enable), 0);
        br_resolve = 1;
        step();
        br_resolve = 0;
        #1;
        check("res_cnt3", 32'(br_inflight), 3);
        check("br5_go", 32'(dispatch_en), 2'b01);
        step();
        check("br5_cnt4", 32'(br_inflight), 4);

        // Drain to 2, then dispatch and resolve together.
        dec_valid = 0; br_resolve = 1;
        step();
        step();
        check("drain_cnt2", 32'(br_inflight), 2);
        dec_valid = 1; dec_is_branch = 1;
        #1;
        check("both_disp", 32'(dispatch_en), 2'b01);
        step();
        check("both_cnt2", 32'(br_inflight), 2);
        br_resolve = 0;
        step();
        check("pre_mis_cnt3", 32'(br_inflight), 3);

        // Mispredict with a branch presented: redirect, clear count, flush.
        br_mispredict = 1; br_resolve = 1;
        #1;
        check("redir_flush", 32'(if_is_flush), 1);
        check("redir_disp", 32'(dispatch_en), 0);
        check("redir_rob", 32'(rob_enable), 0);
        step();
        br_mispredict = 0; br_resolve = 0; dec_is_branch = 0;
        check("mis_cnt0", 32'(br_inflight), 0);
        check("fl1_busy", 32'(flush_busy), 1);
        #1;
        check("fl1_disp", 32'(dispatch_en), 0);
        check("fl1_flush", 32'(if_is_flush), 1);
        check("fl1_ifis", 32'(if_is_enable), 1);
        step();
        check("fl2_busy", 32'(flush_busy), 1);
        check("fl2_disp", 32'(dispatch_en), 0);
        step();
        #1;
        check("run_busy", 32'(flush_busy), 0);
        check("run_disp", 32'(dispatch_en), 2'b01);

        // Second mispredict in the first FLUSH cycle reloads the hold counter.
        br_mispredict = 1; br_resolve = 1;
        step();
        check("ext1_busy", 32'(flush_busy), 1);
        step();
        br_mispredict = 0; br_resolve = 0;
        check("ext2_busy", 32'(flush_busy), 1);
        step();
        check("ext3_busy", 32'(flush_busy), 1);
        check("ext3_disp", 32'(dispatch_en), 0);
        step();
        #1;
        check("ext_run_busy", 32'(flush_busy), 0);
        check("ext_run_disp", 32'(dispatch_en), 2'b01);

        // Fresh reset, then 20 stalled cycles for the statistics counter.
        idle();
        reset_n = 0;
        @(negedge clock);
        reset_n = 1;
        dec_valid = 1; rob_full = 1;
        for (int k = 0; k < 20; k++) step();
`ifdef HAZARD_STATS_EN
        check("stats_sat", 32'(stall_cycles), 15);
`else
        check("stats_off", 32'(stall_cycles), 0);
`endif

        // Reset asserted mid-FLUSH takes effect immediately.
        br_mispredict = 1; br_resolve = 1;
        step();
        br_mispredict = 0; br_resolve = 0;
        check("pre_rst_busy", 32'(flush_busy), 1);
        #1;
        reset_n = 0;
        #1;
        check("midrst_busy", 32'(flush_busy), 0);
        check("midrst_stats", 32'(stall_cycles), 0);
        check("midrst_cnt", 32'(br_inflight), 0);
        check("midrst_ifis", 32'(if_is_enable), 0);
        @(negedge clock);
        reset_n = 1;
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
